// File: rtl/mc_ctrl_fsm_if.sv
// Memory-side handshake between the multicycle control unit and the
// instruction/data memory: access strobes, store lanes, address low bits and ready.
interface mc_ctrl_fsm_if;
  logic       memread;
  logic       memwrite;
  logic [3:0] mem_be;
  logic       ld_sel;
  logic [1:0] addr_lo;
  logic       mem_ready;

  modport master (
    output memread, memwrite, mem_be, ld_sel,
    input  addr_lo, mem_ready
  );

  modport slave (
    input  memread, memwrite, mem_be, ld_sel,
    output addr_lo, mem_ready
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM (IF/DCD/EXE/MEM/WB/EXC) with memory handshake,
// exceptions and a retired-instruction counter. Define MC_CTRL_IRQ_EN to add the irq input.
module mc_ctrl_fsm #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MC_CTRL_IRQ_EN
  input  logic               irq,
`endif
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               gtz,
  input  logic               of_flag,
  mc_ctrl_fsm_if.master      mem,
  output logic [2:0]         state,
  output logic               irwr,
  output logic               pcwr,
  output logic [2:0]         npc_sel,
  output logic [ALUOP_W-1:0] aluop,
  output logic               alusrc,
  output logic               ext_sel,
  output logic               regwrite,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic               exc_valid,
  output logic [1:0]         exc_cause,
  output logic               epc_wr,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                         OP_BEQ = 6'b000100, OP_BGTZ = 6'b000111, OP_ADDI = 6'b001000,
                         OP_ADDIU = 6'b001001, OP_ORI = 6'b001101, OP_LUI = 6'b001111,
                         OP_LB = 6'b100000, OP_LW = 6'b100011, OP_SB = 6'b101000,
                         OP_SH = 6'b101001, OP_SW = 6'b101011;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011,
                         FN_SLT = 6'b101010, FN_JR = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0), ALU_OR = ALUOP_W'(1),
                                 ALU_SLT = ALUOP_W'(2), ALU_SUB = ALUOP_W'(3),
                                 ALU_LUI = ALUOP_W'(4), ALU_NONE = '1;

  state_t           state_q, next_state;
  logic [1:0]       cause_q, next_cause;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic is_r, is_j, is_jal, is_jr, is_beq, is_bgtz, is_addi, is_addiu, is_ori, is_lui;
  logic is_lb, is_lw, is_sb, is_sh, is_sw, is_load, is_store, r_legal, illegal, misaligned;
  logic [3:0] lane_be;

  assign is_r     = (opcode == OP_R);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bgtz  = (opcode == OP_BGTZ);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_addiu = (opcode == OP_ADDIU);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lb    = (opcode == OP_LB);
  assign is_lw    = (opcode == OP_LW);
  assign is_sb    = (opcode == OP_SB);
  assign is_sh    = (opcode == OP_SH);
  assign is_sw    = (opcode == OP_SW);
  assign is_load  = is_lb | is_lw;
  assign is_store = is_sb | is_sh | is_sw;
  assign is_jr    = is_r & (funct == FN_JR);
  assign r_legal  = (funct == FN_ADDU) | (funct == FN_SUBU) | (funct == FN_SLT) | (funct == FN_JR);
  assign illegal  = !((is_r & r_legal) | is_j | is_jal | is_beq | is_bgtz | is_addi |
                      is_addiu | is_ori | is_lui | is_load | is_store);

  // lb/sb are never misaligned; halfwords need an even address, words a zero offset
  assign misaligned = ((is_lw | is_sw) & (mem.addr_lo != 2'b00)) | (is_sh & mem.addr_lo[0]);
  assign lane_be    = is_sw ? 4'b1111 :
                      is_sh ? (4'b0011 << {mem.addr_lo[1], 1'b0}) :
                      is_sb ? (4'b0001 << mem.addr_lo) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      cause_q   <= 2'd0;
      retired_q <= '0;
    end else begin
      state_q <= next_state;
      cause_q <= next_cause;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outputs stay at their idle values while reset is high so an abandoned store never writes
  always_comb begin
    next_state   = state_q;
    next_cause   = cause_q;
    retire       = 1'b0;
    irwr         = 1'b0;
    pcwr         = 1'b0;
    npc_sel      = 3'd0;
    aluop        = ALU_NONE;
    alusrc       = 1'b0;
    ext_sel      = 1'b0;
    mem.memread  = 1'b0;
    mem.memwrite = 1'b0;
    mem.mem_be   = 4'b0000;
    mem.ld_sel   = 1'b0;
    regwrite     = 1'b0;
    regdst       = 2'd0;
    memtoreg     = 2'd0;
    exc_valid    = 1'b0;
    epc_wr       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          mem.memread = 1'b1;
`ifdef MC_CTRL_IRQ_EN
          if (irq) begin
            next_state = S_EXC;
            next_cause = 2'd3;
          end else
`endif
          if (mem.mem_ready) begin
            irwr       = 1'b1;
            pcwr       = 1'b1;
            next_state = S_DCD;
          end
        end
        S_DCD: begin
          if (illegal) begin
            next_state = S_EXC;
            next_cause = 2'd1;
          end else if (is_j) begin
            pcwr       = 1'b1;
            npc_sel    = 3'd2;
            next_state = S_IF;
          end else if (is_jr) begin
            pcwr       = 1'b1;
            npc_sel    = 3'd3;
            next_state = S_IF;
          end else if (is_jal) begin
            next_state = S_WB;
          end else begin
            next_state = S_EXE;
          end
        end
        S_EXE: begin
          ext_sel = !(is_ori | is_addiu);
          alusrc  = is_addi | is_addiu | is_ori | is_lui | is_load | is_store;
          if (is_r)
            aluop = (funct == FN_SUBU) ? ALU_SUB : (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
          else if (is_ori) aluop = ALU_OR;
          else if (is_lui) aluop = ALU_LUI;
          else if (is_beq) aluop = ALU_SUB;
          else if (!is_bgtz) aluop = ALU_ADD;
          if (is_beq | is_bgtz) begin
            npc_sel    = 3'd1;
            pcwr       = is_beq ? zero : gtz;
            next_state = S_IF;
          end else if (is_load | is_store) begin
            next_state = S_MEM;
          end else if (is_addi & of_flag) begin
            next_state = S_EXC;
            next_cause = 2'd0;
          end else begin
            next_state = S_WB;
          end
        end
        S_MEM: begin
          if (misaligned) begin
            next_state = S_EXC;
            next_cause = 2'd2;
          end else begin
            mem.memread  = is_load;
            mem.ld_sel   = is_lb;
            mem.memwrite = is_store;
            mem.mem_be   = lane_be;
            if (mem.mem_ready) next_state = is_load ? S_WB : S_IF;
          end
        end
        S_WB: begin
          regwrite   = 1'b1;
          regdst     = is_r ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
          memtoreg   = is_load ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
          pcwr       = is_jal;
          npc_sel    = is_jal ? 3'd2 : 3'd0;
          next_state = S_IF;
        end
        S_EXC: begin
          exc_valid  = 1'b1;
          epc_wr     = 1'b1;
          pcwr       = 1'b1;
          npc_sel    = 3'd4;
          next_state = S_IF;
        end
        default: next_state = S_IF;
      endcase
      retire = (next_state == S_IF) &&
               ((state_q == S_DCD) || (state_q == S_EXE) || (state_q == S_MEM) || (state_q == S_WB));
    end
  end

  assign state     = state_q;
  assign exc_cause = cause_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, queue-scoreboarded bench for mc_ctrl_fsm; every cycle's expected
// outputs are hand-computed and pushed, and a negedge monitor pops and compares.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       irwr;
    logic       pcwr;
    logic [2:0] npc_sel;
    logic [2:0] aluop;
    logic       alusrc;
    logic       ext_sel;
    logic       memread;
    logic       memwrite;
    logic [3:0] mem_be;
    logic       ld_sel;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       exc_valid;
    logic       epc_wr;
  } ctl_t;

  typedef struct {
    string       name;
    bit          chk_st;
    logic [2:0]  st;
    ctl_t        c;
    logic [1:0]  cause;
    logic [31:0] ret;
  } exp_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                         OP_BEQ = 6'b000100, OP_BGTZ = 6'b000111, OP_ADDI = 6'b001000,
                         OP_ORI = 6'b001101, OP_LB = 6'b100000, OP_LW = 6'b100011,
                         OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, gtz, of_flag;
  logic [2:0]  state;
  logic        irwr, pcwr, alusrc, ext_sel, regwrite, exc_valid, epc_wr;
  logic [2:0]  npc_sel, aluop;
  logic [1:0]  regdst, memtoreg, exc_cause;
  logic [31:0] retired;
`ifdef MC_CTRL_IRQ_EN
  logic        irq;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   chk_state;
  exp_t sb_q[$];

  mc_ctrl_fsm_if mem_if ();

  mc_ctrl_fsm #(.ALUOP_W(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
`ifdef MC_CTRL_IRQ_EN
    .irq(irq),
`endif
    .opcode(opcode), .funct(funct), .zero(zero), .gtz(gtz), .of_flag(of_flag),
    .mem(mem_if), .state(state), .irwr(irwr), .pcwr(pcwr), .npc_sel(npc_sel),
    .aluop(aluop), .alusrc(alusrc), .ext_sel(ext_sel), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .epc_wr(epc_wr), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic ctl_t ci();
    ctl_t c = '0;
    c.aluop = 3'b111;
    return c;
  endfunction

  function automatic ctl_t cf();
    ctl_t c = ci();
    c.memread = 1'b1; c.irwr = 1'b1; c.pcwr = 1'b1;
    return c;
  endfunction

  function automatic ctl_t ce(input logic [2:0] op, input logic src, input logic ext);
    ctl_t c = ci();
    c.aluop = op; c.alusrc = src; c.ext_sel = ext;
    return c;
  endfunction

  function automatic ctl_t cm(input logic rd, input logic wr, input logic [3:0] be, input logic ls);
    ctl_t c = ci();
    c.memread = rd; c.memwrite = wr; c.mem_be = be; c.ld_sel = ls;
    return c;
  endfunction

  function automatic ctl_t cw(input logic [1:0] dst, input logic [1:0] m2r);
    ctl_t c = ci();
    c.regwrite = 1'b1; c.regdst = dst; c.memtoreg = m2r;
    return c;
  endfunction

  function automatic ctl_t cx();
    ctl_t c = ci();
    c.exc_valid = 1'b1; c.epc_wr = 1'b1; c.pcwr = 1'b1; c.npc_sel = 3'd4;
    return c;
  endfunction

  task automatic apply_stimulus(input string nm, input logic [2:0] st, input ctl_t c,
                                input logic [1:0] cause, input logic [31:0] ret);
    exp_t e;
    e.name = nm; e.chk_st = chk_state; e.st = st; e.c = c; e.cause = cause; e.ret = ret;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input exp_t e);
    ctl_t a;
    a = '{irwr, pcwr, npc_sel, aluop, alusrc, ext_sel, mem_if.memread, mem_if.memwrite,
          mem_if.mem_be, mem_if.ld_sel, regwrite, regdst, memtoreg, exc_valid, epc_wr};
    if (e.chk_st) begin
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("[TB] FAIL %s state: got %0d expected %0d", e.name, state, e.st);
      end
    end
    checks++;
    if (a !== e.c) begin
      errors++;
      $display("[TB] FAIL %s ctl: got %p expected %p", e.name, a, e.c);
    end
    checks++;
    if (exc_cause !== e.cause) begin
      errors++;
      $display("[TB] FAIL %s exc_cause: got %0d expected %0d", e.name, exc_cause, e.cause);
    end
    checks++;
    if (retired !== e.ret) begin
      errors++;
      $display("[TB] FAIL %s retired: got %0d expected %0d", e.name, retired, e.ret);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) check_output(sb_q.pop_front());
  end

  initial begin
    ctl_t e;
    reset = 1'b1; opcode = OP_R; funct = 6'b100001; zero = 1'b0; gtz = 1'b0; of_flag = 1'b0;
    mem_if.addr_lo = 2'd0; mem_if.mem_ready = 1'b1; chk_state = 1'b1;
`ifdef MC_CTRL_IRQ_EN
    irq = 1'b0;
`endif
    @(posedge clk); #1;
    apply_stimulus("rst0", 3'd0, ci(), 2'd0, 0);
    apply_stimulus("rst1", 3'd0, ci(), 2'd0, 0);
    reset = 1'b0;

    apply_stimulus("addu_if",  3'd0, cf(), 2'd0, 0);
    apply_stimulus("addu_dcd", 3'd1, ci(), 2'd0, 0);
    apply_stimulus("addu_exe", 3'd2, ce(3'd0, 1'b0, 1'b1), 2'd0, 0);
    apply_stimulus("addu_wb",  3'd4, cw(2'd1, 2'd0), 2'd0, 0);

    opcode = OP_SW;
    apply_stimulus("sw_if",  3'd0, cf(), 2'd0, 1);
    apply_stimulus("sw_dcd", 3'd1, ci(), 2'd0, 1);
    apply_stimulus("sw_exe", 3'd2, ce(3'd0, 1'b1, 1'b1), 2'd0, 1);
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus("sw_mem_wait", 3'd3, cm(1'b0, 1'b1, 4'b1111, 1'b0), 2'd0, 1);
    mem_if.mem_ready = 1'b1;
    apply_stimulus("sw_mem_rdy", 3'd3, cm(1'b0, 1'b1, 4'b1111, 1'b0), 2'd0, 1);

    opcode = OP_SB; mem_if.addr_lo = 2'd2;
    apply_stimulus("sb_if",  3'd0, cf(), 2'd0, 2);
    apply_stimulus("sb_dcd", 3'd1, ci(), 2'd0, 2);
    apply_stimulus("sb_exe", 3'd2, ce(3'd0, 1'b1, 1'b1), 2'd0, 2);
    apply_stimulus("sb_mem", 3'd3, cm(1'b0, 1'b1, 4'b0100, 1'b0), 2'd0, 2);

    opcode = OP_SH;
    apply_stimulus("sh2_if",  3'd0, cf(), 2'd0, 3);
    apply_stimulus("sh2_dcd", 3'd1, ci(), 2'd0, 3);
    apply_stimulus("sh2_exe", 3'd2, ce(3'd0, 1'b1, 1'b1), 2'd0, 3);
    apply_stimulus("sh2_mem", 3'd3, cm(1'b0, 1'b1, 4'b1100, 1'b0), 2'd0, 3);

    mem_if.addr_lo = 2'd1;
    apply_stimulus("sh1_if",  3'd0, cf(), 2'd0, 4);
    apply_stimulus("sh1_dcd", 3'd1, ci(), 2'd0, 4);
    apply_stimulus("sh1_exe", 3'd2, ce(3'd0, 1'b1, 1'b1), 2'd0, 4);
    apply_stimulus("sh1_mem", 3'd3, ci(), 2'd0, 4);
    apply_stimulus("sh1_exc", 3'd5, cx(), 2'd2, 4);

    opcode = OP_ADDI; mem_if.addr_lo = 2'd0;
    apply_stimulus("addi_if",  3'd0, cf(), 2'd2, 4);
    apply_stimulus("addi_dcd", 3'd1, ci(), 2'd2, 4);
    of_flag = 1'b1;
    apply_stimulus("addi_exe", 3'd2, ce(3'd0, 1'b1, 1'b1), 2'd2, 4);
    of_flag = 1'b0;
    apply_stimulus("addi_exc", 3'd5, cx(), 2'd0, 4);

    opcode = OP_LW;
    apply_stimulus("lw_if",  3'd0, cf(), 2'd0, 4);
    apply_stimulus("lw_dcd", 3'd1, ci(), 2'd0, 4);
    apply_stimulus("lw_exe", 3'd2, ce(3'd0, 1'b1, 1'b1), 2'd0, 4);
    apply_stimulus("lw_mem", 3'd3, cm(1'b1, 1'b0, 4'b0000, 1'b0), 2'd0, 4);
    apply_stimulus("lw_wb",  3'd4, cw(2'd0, 2'd1), 2'd0, 4);

    opcode = OP_LB; mem_if.addr_lo = 2'd3;
    apply_stimulus("lb_if",  3'd0, cf(), 2'd0, 5);
    apply_stimulus("lb_dcd", 3'd1, ci(), 2'd0, 5);
    apply_stimulus("lb_exe", 3'd2, ce(3'd0, 1'b1, 1'b1), 2'd0, 5);
    apply_stimulus("lb_mem", 3'd3, cm(1'b1, 1'b0, 4'b0000, 1'b1), 2'd0, 5);
    apply_stimulus("lb_wb",  3'd4, cw(2'd0, 2'd1), 2'd0, 5);

    opcode = OP_BEQ; mem_if.addr_lo = 2'd0; zero = 1'b0;
    apply_stimulus("beq_if",  3'd0, cf(), 2'd0, 6);
    apply_stimulus("beq_dcd", 3'd1, ci(), 2'd0, 6);
    e = ce(3'd3, 1'b0, 1'b1); e.npc_sel = 3'd1;
    apply_stimulus("beq_exe", 3'd2, e, 2'd0, 6);

    opcode = OP_BGTZ; gtz = 1'b1;
    apply_stimulus("bgtz_if",  3'd0, cf(), 2'd0, 7);
    apply_stimulus("bgtz_dcd", 3'd1, ci(), 2'd0, 7);
    e = ce(3'd7, 1'b0, 1'b1); e.npc_sel = 3'd1; e.pcwr = 1'b1;
    apply_stimulus("bgtz_exe", 3'd2, e, 2'd0, 7);
    gtz = 1'b0;

    opcode = OP_JAL;
    apply_stimulus("jal_if",  3'd0, cf(), 2'd0, 8);
    apply_stimulus("jal_dcd", 3'd1, ci(), 2'd0, 8);
    e = cw(2'd2, 2'd2); e.pcwr = 1'b1; e.npc_sel = 3'd2;
    apply_stimulus("jal_wb",  3'd4, e, 2'd0, 8);

    opcode = OP_J;
    apply_stimulus("j_if",  3'd0, cf(), 2'd0, 9);
    e = ci(); e.pcwr = 1'b1; e.npc_sel = 3'd2;
    apply_stimulus("j_dcd", 3'd1, e, 2'd0, 9);

    opcode = OP_R; funct = 6'b001000;
    apply_stimulus("jr_if",  3'd0, cf(), 2'd0, 10);
    e = ci(); e.pcwr = 1'b1; e.npc_sel = 3'd3;
    apply_stimulus("jr_dcd", 3'd1, e, 2'd0, 10);

    opcode = 6'b111111;
    apply_stimulus("ill_if",  3'd0, cf(), 2'd0, 11);
    apply_stimulus("ill_dcd", 3'd1, ci(), 2'd0, 11);
    apply_stimulus("ill_exc", 3'd5, cx(), 2'd1, 11);

    opcode = OP_ORI; mem_if.mem_ready = 1'b0;
    e = ci(); e.memread = 1'b1;
    apply_stimulus("if_stall", 3'd0, e, 2'd1, 11);
    mem_if.mem_ready = 1'b1;
    apply_stimulus("ori_if",  3'd0, cf(), 2'd1, 11);
    apply_stimulus("ori_dcd", 3'd1, ci(), 2'd1, 11);
    apply_stimulus("ori_exe", 3'd2, ce(3'd1, 1'b1, 1'b0), 2'd1, 11);
    apply_stimulus("ori_wb",  3'd4, cw(2'd0, 2'd0), 2'd1, 11);

    opcode = OP_SW;
    apply_stimulus("swr_if",  3'd0, cf(), 2'd1, 12);
    apply_stimulus("swr_dcd", 3'd1, ci(), 2'd1, 12);
    apply_stimulus("swr_exe", 3'd2, ce(3'd0, 1'b1, 1'b1), 2'd1, 12);
    mem_if.mem_ready = 1'b0;
    apply_stimulus("swr_mem", 3'd3, cm(1'b0, 1'b1, 4'b1111, 1'b0), 2'd1, 12);
    reset = 1'b1; chk_state = 1'b0;
    apply_stimulus("swr_reset", 3'd3, ci(), 2'd1, 12);
    reset = 1'b0; chk_state = 1'b1;
    e = ci(); e.memread = 1'b1;
    apply_stimulus("post_reset", 3'd0, e, 2'd0, 0);
    mem_if.mem_ready = 1'b1;

`ifdef MC_CTRL_IRQ_EN
    irq = 1'b1;
    e = ci(); e.memread = 1'b1;
    apply_stimulus("irq_if", 3'd0, e, 2'd0, 0);
    irq = 1'b0;
    apply_stimulus("irq_exc", 3'd5, cx(), 2'd3, 0);
    apply_stimulus("irq_refetch", 3'd0, cf(), 2'd3, 0);
`endif

    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Next-generation multicycle MIPS control unit. It sequences IF/DCD/EXE/MEM/WB plus a new EXC state, and adds a memory-ready handshake on fetch and data access. It adds byte-lane store enables, alignment and illegal-opcode exceptions, and a retired-instruction counter. It drives the datapath select/enable lines; the datapath owns the PC, IR, regfile, ALU and DM.

Parameters:
ALUOP_W, 3, width of aluop (>=3); codes zero-extended: 0 add, 1 or, 2 slt, 3 sub, 4 lui, all-ones = none.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU result == 0
gtz  in  1  rs > 0 (signed)
of_flag  in  1  ALU signed overflow, valid in EXE
addr_lo  in  2  ALU-out register [1:0], valid in MEM
mem_ready  in  1  memory completes access this cycle
state  out  3  0 IF, 1 DCD, 2 EXE, 3 MEM, 4 WB, 5 EXC
irwr  out  1  IR write
pcwr  out  1  PC write
npc_sel  out  3  0 +4, 1 branch, 2 j/jal, 3 jr, 4 exception vector
aluop  out  ALUOP_W  ALU operation
alusrc  out  1  1 imm, 0 rt
ext_sel  out  1  1 sign, 0 zero
memread  out  1  memory read strobe
memwrite  out  1  DM write strobe
mem_be  out  4  store byte lanes
ld_sel  out  1  0 word, 1 signed byte (lane = addr_lo)
regwrite  out  1  regfile write
regdst  out  2  0 rt, 1 rd, 2 $31
memtoreg  out  2  0 ALU, 1 mem, 2 PC+4
exc_valid  out  1  exception taken (pulse)
exc_cause  out  2  0 overflow, 1 illegal, 2 misaligned, 3 interrupt
epc_wr  out  1  capture PC into EPC
retired  out  CNT_W  completed instruction count

Behaviour:
- Reset: state=IF, every strobe/select output 0, aluop all-ones, exc_cause 0, retired 0. Reset mid-access abandons the access; memwrite is 0 in the reset cycle.
- Opcodes: R 000000, j 000010, jal 000011, beq 000100, bgtz 000111, addi 001000, addiu 001001, ori 001101, lui 001111, lb 100000, lw 100011, sb 101000, sh 101001, sw 101011.
- Functs: addu 100001, subu 100011, slt 101010, jr 001000. Anything else is illegal.
- All control outputs are combinational from state and inputs; only state, cause and the counter are registered.
- IF: memread=1. If mem_ready=1: irwr=pcwr=1, npc_sel=0, go to DCD. Otherwise hold IF with irwr=pcwr=0.
- DCD:
  - j: pcwr=1, npc_sel=2, go to IF.
  - jr: pcwr=1, npc_sel=3, go to IF.
  - jal: go to WB.
  - illegal: go to EXC, cause=1.
  - else: go to EXE.
- EXE: aluop, alusrc and ext_sel decoded per op; ext_sel=0 only for ori/addiu.
  - beq: aluop=sub, npc_sel=1, pcwr=zero, go to IF.
  - bgtz: npc_sel=1, pcwr=gtz, go to IF.
  - Loads/stores: go to MEM.
  - addi with of_flag=1: go to EXC, cause=0.
  - else: go to WB.
- MEM:
  - Misaligned access (lw/sw addr_lo!=0; sh addr_lo[0]=1): go to EXC, cause=2, no memread/memwrite.
  - Loads: memread=1, ld_sel=(lb). Stores: memwrite=1.
  - mem_be: sw 1111; sh 0011<<(2*addr_lo[1]); sb 0001<<addr_lo; 0000 otherwise.
  - Hold MEM while mem_ready=0 with strobes asserted. On mem_ready: loads go to WB, stores go to IF.
- WB: regwrite=1.
  - regdst: R=1, jal=2, else 0.
  - memtoreg: loads 1, jal 2, else 0.
  - jal: additionally pcwr=1, npc_sel=2.
  - Always go to IF.
- EXC: one cycle, exc_valid=1, epc_wr=1, pcwr=1, npc_sel=4, regwrite=0, go to IF. exc_cause is held until the next exception.
- retired: increments by 1 on each transition into IF from DCD/EXE/MEM/WB. It does not increment from EXC or on IF stalls, and wraps modulo 2^CNT_W.
- Unused state encodings 6/7: go to IF with outputs as in reset.

Optional Feature:
MC_CTRL_IRQ_EN: adds input irq (1 bit). When defined, irq=1 sampled in IF (before fetch completes) sends the FSM to EXC with cause=3, with no irwr/pcwr in that cycle; irq is ignored in other states. When undefined, the port is absent and cause 3 never occurs.

Test Plan:
- reset=1 for 2 cycles, mem_ready=1 -> state=0, retired=0; then addu runs IF,DCD,EXE,WB (4 cycles) with regdst=1, regwrite=1 in WB, retired=1.
- sw with mem_ready low for 3 MEM cycles -> memwrite=1, mem_be=1111 held for 4 cycles; state returns to IF after the ready cycle; retired +1.
- sb addr_lo=2 -> mem_be=0100. sh addr_lo=2 -> 1100. sh addr_lo=1 -> EXC, cause=2, memwrite never 1.
- addi with of_flag=1 in EXE -> EXC next cycle: exc_valid=1, npc_sel=4, regwrite=0 throughout; retired unchanged.
- beq zero=0 -> pcwr=0 in EXE; bgtz gtz=1 -> pcwr=1, npc_sel=1. jal -> WB: regdst=2, memtoreg=2, npc_sel=2, pcwr=1.
- opcode 111111 -> DCD to EXC, cause=1. With MC_CTRL_IRQ_EN, irq=1 in IF -> EXC, cause=3, irwr=0.
